// File: rtl/pin_loopback_pkg.sv
// ============================================================================
// pin_loopback_pkg : shared encodings and PRBS7 helpers for pin_loopback_checker
// Revision: 1.0
// ============================================================================
`default_nettype none

package pin_loopback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [6:0] PRBS7_SEED  = 7'h01;
    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;

    localparam int CH_FF   = 0;
    localparam int CH_PASS = 1;
    localparam int CH_OP   = 2;

    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/prbs7_gen.sv
// ============================================================================
// prbs7_gen : 7-bit Fibonacci LFSR with load/advance controls
// Revision: 1.0
// ============================================================================
`default_nettype none

module prbs7_gen
    import pin_loopback_pkg::*;
(
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Load,
    input  logic i_Advance,
    output logic o_Bit
);

    logic [6:0] state_q;
    logic [6:0] state_d;

    // Load primes the register one step past the seed: the top emits the
    // seed's own bit directly on the start edge, so o_Bit always leads o_Data.
    always_comb begin
        state_d = state_q;
        if (i_Load) begin
            state_d = prbs7_next(PRBS7_SEED);
        end else if (i_Advance) begin
            state_d = prbs7_next(state_q);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q <= PRBS7_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_Bit = state_q[6];

endmodule

`default_nettype wire

// File: rtl/pin_loopback_checker.sv
// ============================================================================
// pin_loopback_checker : PRBS7 stimulus and three-channel return checker.
// Optional error injection via PIN_LOOPBACK_CHECKER_ERR_INJECT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pin_loopback_checker
    import pin_loopback_pkg::*;
#(
    parameter int TEST_LEN      = 1024,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Start,
    output logic                     o_Data,
    input  logic                     i_DataFF,
    input  logic                     i_DataPassthrough,
    input  logic                     i_DataOp,
`ifdef PIN_LOOPBACK_CHECKER_ERR_INJECT_EN
    input  logic                     i_InjectErr,
`endif
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_Pass,
    output logic [ERR_CNT_WIDTH-1:0] o_ErrCount,
    output logic [2:0]               o_ErrMask
);

    localparam logic [15:0]              LAST_IDX = 16'(TEST_LEN - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE  = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [15:0]              idx_q, idx_d;
    logic                     data_q, data_d;
    logic                     prev_q, prev_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     pass_q, pass_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]               mask_q, mask_d;
    logic [2:0]               mis;
    logic                     inject;
    logic                     prbs_load;
    logic                     prbs_adv;
    logic                     prbs_bit;

`ifdef PIN_LOOPBACK_CHECKER_ERR_INJECT_EN
    assign inject = i_InjectErr;
`else
    assign inject = 1'b0;
`endif

    prbs7_gen u_prbs (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Load    (prbs_load),
        .i_Advance (prbs_adv),
        .o_Bit     (prbs_bit)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = 1'b0;
        prev_d    = data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        prbs_load = 1'b0;
        prbs_adv  = 1'b0;

        // prev_q holds last cycle's stimulus; it is stale at k=0, hence the gate.
        mis[CH_FF]   = (idx_q != 16'd0) && (i_DataFF != prev_q);
        mis[CH_PASS] = i_DataPassthrough != (data_q ^ inject);
        mis[CH_OP]   = i_DataOp != ~data_q;

        case (state_q)
            ST_RUN: begin
                prbs_adv = 1'b1;
                mask_d   = mask_q | mis;
                if ((|mis) && (cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (cnt_d == '0);
                end else begin
                    idx_d  = idx_q + 16'd1;
                    data_d = prbs_bit;
                end
            end
            default: begin
                if (i_Start) begin
                    state_d   = ST_RUN;
                    idx_d     = 16'd0;
                    data_d    = PRBS7_SEED[6];
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    cnt_d     = '0;
                    mask_d    = 3'b000;
                    prbs_load = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 16'd0;
            data_q  <= 1'b0;
            prev_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            mask_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            prev_q  <= prev_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    assign o_Data     = data_q;
    assign o_Busy     = busy_q;
    assign o_Done     = done_q;
    assign o_Pass     = pass_q;
    assign o_ErrCount = cnt_q;
    assign o_ErrMask  = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_pin_loopback_checker.sv
// ============================================================================
// tb_pin_loopback_checker : directed and randomized bench for pin_loopback_checker
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pin_loopback_checker;

    localparam int TEST_LEN = 16;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    // Return-path behaviours: 0 ideal, 1 stuck-0, 2 stuck-1, 3 miswired, 4 random flips
    logic             clk = 1'b0;
    logic             rst_n, start, inject;
    logic             ret_ff, ret_pass, ret_op;
    logic             data, busy, done, pass;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mask;
    logic             prev_data;
    logic             flip_ff, flip_pass, flip_op;
    int               mode_ff, mode_pass, mode_op;
    int               n_tests = 0;
    int               n_fail  = 0;
    logic             eb [TEST_LEN];

    always #5 clk = ~clk;

    pin_loopback_checker #(
        .TEST_LEN      (TEST_LEN),
        .ERR_CNT_WIDTH (CNT_W)
    ) dut (
        .i_Clock           (clk),
        .i_Reset           (rst_n),
        .i_Start           (start),
        .o_Data            (data),
        .i_DataFF          (ret_ff),
        .i_DataPassthrough (ret_pass),
        .i_DataOp          (ret_op),
`ifdef PIN_LOOPBACK_CHECKER_ERR_INJECT_EN
        .i_InjectErr       (inject),
`endif
        .o_Busy            (busy),
        .o_Done            (done),
        .o_Pass            (pass),
        .o_ErrCount        (cnt),
        .o_ErrMask         (mask)
    );

    function automatic logic ret_value(input int mode, input logic ideal,
                                       input logic miswired, input logic flip);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return miswired;
            4:       return ideal ^ flip;
            default: return ideal;
        endcase
    endfunction

    always @(posedge clk) prev_data <= data;

    always_comb begin
        ret_ff   = ret_value(mode_ff,   prev_data, data,  flip_ff);
        ret_pass = ret_value(mode_pass, data,      ~data, flip_pass);
        ret_op   = ret_value(mode_op,   ~data,     data,  flip_op);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_cnt"},  32'(cnt),  32'd0);
        check({tag, "_mask"}, 32'(mask), 32'd0);
    endtask

    // Called just after an active edge; returns just after an active edge.
    task automatic run_test(input int mff, input int mp, input int mop,
                            input int abort_k, input bit start_mid,
                            input int inj_lo, input int inj_hi, input int plan_cnt);
        int   exp_cnt;
        logic [2:0] exp_mask;
        logic a_ff, a_pass, a_op, inj_eff;
        logic [2:0] mm;
        mode_ff = mff; mode_pass = mp; mode_op = mop;
        flip_ff = 1'b0; flip_pass = 1'b0; flip_op = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_cnt = 0;
        exp_mask = 3'b000;
        check("start_cnt_clear",  32'(cnt),  32'd0);
        check("start_mask_clear", 32'(mask), 32'd0);
        check("start_pass_clear", 32'(pass), 32'd0);
        for (int k = 0; k < TEST_LEN; k++) begin
            check("run_data", 32'(data), 32'(eb[k]));
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            if (abort_k == k) begin
                rst_n = 1'b0;
                start = 1'b1;
                @(posedge clk); #1;
                check_idle_zero("abort");
                @(posedge clk); #1;
                check_idle_zero("abort_hold");
                rst_n = 1'b1;
                start = 1'b0;
                inject = 1'b0;
                @(posedge clk); #1;
                check("abort_idle_busy", 32'(busy), 32'd0);
                return;
            end
            flip_ff   = 1'($urandom_range(0, 1));
            flip_pass = 1'($urandom_range(0, 1));
            flip_op   = 1'($urandom_range(0, 1));
            inject    = (k >= inj_lo) && (k <= inj_hi);
            start     = start_mid && (k == 5);
`ifdef PIN_LOOPBACK_CHECKER_ERR_INJECT_EN
            inj_eff = inject;
`else
            inj_eff = 1'b0;
`endif
            a_ff   = ret_value(mff, (k > 0) ? eb[k-1] : 1'b0, eb[k], flip_ff);
            a_pass = ret_value(mp,  eb[k],  ~eb[k], flip_pass);
            a_op   = ret_value(mop, ~eb[k], eb[k],  flip_op);
            mm[0] = (k > 0) && (a_ff != eb[k-1]);
            mm[1] = a_pass != (eb[k] ^ inj_eff);
            mm[2] = a_op != ~eb[k];
            exp_mask = exp_mask | mm;
            if (mm != 3'b000 && exp_cnt < CNT_MAX) exp_cnt++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        inject = 1'b0;
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_data", 32'(data), 32'd0);
        check("end_cnt",  32'(cnt),  32'(exp_cnt));
        check("end_mask", 32'(mask), 32'(exp_mask));
        check("end_pass", 32'(pass), 32'(exp_cnt == 0));
        if (plan_cnt >= 0) check("plan_cnt", 32'(cnt), 32'(plan_cnt));
        @(posedge clk); #1;
        check("hold_done", 32'(done), 32'd1);
        check("hold_cnt",  32'(cnt),  32'(exp_cnt));
    endtask

    initial begin
        int s;
        s = 1;
        for (int k = 0; k < TEST_LEN; k++) begin
            eb[k] = 1'((s >> 6) & 1);
            s = ((s << 1) & 127) | (((s >> 6) ^ (s >> 5)) & 1);
        end

        rst_n = 1'b0; start = 1'b0; inject = 1'b0;
        mode_ff = 0; mode_pass = 0; mode_op = 0;
        flip_ff = 1'b0; flip_pass = 1'b0; flip_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        run_test(0, 0, 0, -1, 1'b0, -1, -1, 0);      // ideal DUT
        run_test(0, 1, 0, -1, 1'b0, -1, -1, 3);      // passthrough stuck at 0
        run_test(0, 0, 3, -1, 1'b0, -1, -1, CNT_MAX); // missing inverter, 16 saturates
        run_test(3, 0, 0, -1, 1'b0, -1, -1, 4);      // FF without delay
        run_test(0, 0, 0, 8,  1'b0, -1, -1, -1);     // reset aborts at cycle 8
        run_test(0, 0, 0, -1, 1'b0, -1, -1, 0);      // fresh test after abort
        run_test(0, 0, 0, -1, 1'b1, -1, -1, 0);      // start ignored mid-run
        run_test(2, 0, 0, -1, 1'b0, -1, -1, -1);     // FF stuck at 1
`ifdef PIN_LOOPBACK_CHECKER_ERR_INJECT_EN
        run_test(0, 0, 0, -1, 1'b0, 3, 5, 3);
        run_test(0, 0, 0, -1, 1'b0, -1, -1, 0);
`endif
        for (int r = 0; r < 12; r++) begin
            int lo;
            lo = $urandom_range(0, TEST_LEN - 1);
            run_test($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                     -1, 1'($urandom_range(0, 1)), lo, lo + $urandom_range(0, 3), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
